// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of the write-port arbiter's request, regfile and hazard-query signals.
// master: pipeline/mul-div/hazard side; slave: the arbiter itself.
interface regfile_wr_arbiter_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
);
    // Primary (WB stage) write request
    logic                     wb_valid;
    logic [4:0]               wb_reg;
    logic [WIDTH-1:0]         wb_data;
    // Secondary (long-latency unit) write request
    logic                     mu_valid;
    logic [4:0]               mu_reg;
    logic [WIDTH-1:0]         mu_data;
    logic                     mu_ready;
    // Pipeline control and regfile write port
    logic                     stall_wb;
    logic                     RegWrite;
    logic [4:0]               WriteRegister;
    logic [WIDTH-1:0]         WriteData;
    // Hazard queries
    logic [4:0]               rd_reg1;
    logic [4:0]               rd_reg2;
    logic                     pend_hit1;
    logic                     pend_hit2;
    // Status
    logic [$clog2(DEPTH):0]   fifo_count;
    logic [31:0]              stall_cycles;

    modport master (
        output wb_valid, wb_reg, wb_data, mu_valid, mu_reg, mu_data, rd_reg1, rd_reg2,
        input  mu_ready, stall_wb, RegWrite, WriteRegister, WriteData, pend_hit1, pend_hit2,
               fifo_count, stall_cycles
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data, mu_valid, mu_reg, mu_data, rd_reg1, rd_reg2,
        output mu_ready, stall_wb, RegWrite, WriteRegister, WriteData, pend_hit1, pend_hit2,
               fifo_count, stall_cycles
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter. WB stage has priority; the long-latency unit is buffered
// in a FIFO and forces a one-cycle WB stall after MAX_WAIT denied cycles. Register 31 is
// hardwired zero and never written. Optional stall counter enabled by ARB_PERF_EN.
module regfile_wr_arbiter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned WIDTH    = 64
) (
    input logic                 clk,
    input logic                 reset,
    regfile_wr_arbiter_if.slave bus
);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
    localparam logic [4:0]  ZeroReg = 5'd31;

    logic [4:0]       fifo_reg_q  [DEPTH];
    logic [WIDTH-1:0] fifo_data_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             regwrite_q;
    logic [4:0]       wreg_q;
    logic [WIDTH-1:0] wdata_q;

    logic             empty, full, stall, push, pop, grant;
    logic [4:0]       grant_reg;
    logic [WIDTH-1:0] grant_data;
    logic [PtrW-1:0]  off;
    logic             hit1, hit2;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));
    // Both outputs are forced low while reset is held.
    assign stall = reset && (wait_q == WaitW'(MAX_WAIT)) && !empty;
    assign bus.mu_ready = reset && !full;
    assign bus.stall_wb = stall;
    // Writes to the zero register are acknowledged but never queued.
    assign push = bus.mu_valid && bus.mu_ready && (bus.mu_reg != ZeroReg);

    // Grant selection and starvation counter update.
    always_comb begin
        pop        = 1'b0;
        grant      = 1'b0;
        grant_reg  = bus.wb_reg;
        grant_data = bus.wb_data;
        wait_d     = '0;
        if (stall) begin
            pop        = 1'b1;
            grant      = 1'b1;
            grant_reg  = fifo_reg_q[rd_ptr_q];
            grant_data = fifo_data_q[rd_ptr_q];
        end else if (bus.wb_valid) begin
            grant = 1'b1;
            if (!empty) begin
                wait_d = (wait_q == WaitW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
            end
        end else if (!empty) begin
            pop        = 1'b1;
            grant      = 1'b1;
            grant_reg  = fifo_reg_q[rd_ptr_q];
            grant_data = fifo_data_q[rd_ptr_q];
        end
        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    // FIFO storage; contents need no reset since occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg_q[wr_ptr_q]  <= bus.mu_reg;
            fifo_data_q[wr_ptr_q] <= bus.mu_data;
        end
    end

    // Pointers, occupancy, wait counter and the regfile output register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            wait_q     <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            wait_q     <= wait_d;
            regwrite_q <= grant && (grant_reg != ZeroReg);
            if (grant) begin
                wreg_q  <= grant_reg;
                wdata_q <= grant_data;
            end
        end
    end

    assign bus.RegWrite      = regwrite_q;
    assign bus.WriteRegister = wreg_q;
    assign bus.WriteData     = wdata_q;
    assign bus.fifo_count    = count_q;

    // Hazard lookup across live FIFO slots and the in-flight output register.
    always_comb begin
        hit1 = regwrite_q && (wreg_q == bus.rd_reg1);
        hit2 = regwrite_q && (wreg_q == bus.rd_reg2);
        off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PtrW'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q) begin
                if (fifo_reg_q[i] == bus.rd_reg1) hit1 = 1'b1;
                if (fifo_reg_q[i] == bus.rd_reg2) hit2 = 1'b1;
            end
        end
        bus.pend_hit1 = hit1 && (bus.rd_reg1 != ZeroReg);
        bus.pend_hit2 = hit2 && (bus.rd_reg2 != ZeroReg);
    end

`ifdef ARB_PERF_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of forced WB stalls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
`else
    assign bus.stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model of the arbitration rules.
module tb_regfile_wr_arbiter;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_WAIT = 8;
    localparam int unsigned WIDTH    = 64;
`ifdef ARB_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    regfile_wr_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]       rg;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t             mq[$];
    ent_t             m_e;
    int               m_wait = 0;
    bit               m_rw   = 1'b0;
    logic [4:0]       m_wr   = '0;
    logic [WIDTH-1:0] m_wd   = '0;
    logic [31:0]      m_sc   = '0;
    bit               m_acc, m_stall, m_g;

    function automatic bit m_pend(input logic [4:0] r);
        if (r == 5'd31) return 1'b0;
        foreach (mq[i]) if (mq[i].rg == r) return 1'b1;
        return m_rw && (m_wr == r);
    endfunction

    function automatic bit m_stall_now();
        return rst_n && (m_wait == MAX_WAIT) && (mq.size() != 0);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_wait = 0;
            m_rw   = 1'b0;
            m_wr   = '0;
            m_wd   = '0;
            m_sc   = '0;
        end else begin
            m_acc   = bus.mu_valid && (mq.size() < DEPTH);
            m_stall = (m_wait == MAX_WAIT) && (mq.size() != 0);
            m_g     = 1'b0;
            if (m_stall) begin
                m_e = mq.pop_front();
                m_g = 1'b1;
                m_wait = 0;
                if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            end else if (bus.wb_valid) begin
                m_e = {bus.wb_reg, bus.wb_data};
                m_g = 1'b1;
                if (mq.size() == 0) m_wait = 0;
                else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
            end else if (mq.size() != 0) begin
                m_e = mq.pop_front();
                m_g = 1'b1;
                m_wait = 0;
            end
            if (m_g) begin
                m_rw = (m_e.rg != 5'd31);
                m_wr = m_e.rg;
                m_wd = m_e.d;
            end else begin
                m_rw = 1'b0;
            end
            if (m_acc && bus.mu_reg != 5'd31) mq.push_back({bus.mu_reg, bus.mu_data});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_valid = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
        bus.mu_valid = 1'b0; bus.mu_reg = '0; bus.mu_data = '0;
        bus.rd_reg1  = 5'd31; bus.rd_reg2 = 5'd31;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.mu_valid = 1'b1; bus.mu_reg = 5'd4; bus.mu_data = 64'h44;
        step(); step();
        total++; if (bus.mu_ready !== 1'b0) begin bad++; $display("FAIL reset_mu_ready got=%0b want=0", bus.mu_ready); end
        total++; if (bus.RegWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%0b want=0", bus.RegWrite); end
        total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.fifo_count); end
        total++; if (bus.stall_wb !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", bus.stall_wb); end
        total++; if (bus.WriteRegister !== 5'd0) begin bad++; $display("FAIL reset_wreg got=%0d want=0", bus.WriteRegister); end
        bus.mu_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        total++; if (bus.mu_ready !== 1'b1) begin bad++; $display("FAIL release_mu_ready got=%0b want=1", bus.mu_ready); end
    endtask

    task automatic test_wb_write();
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 64'hAA;
        step();
        bus.wb_valid = 1'b0;
        #1;
        total++; if (bus.RegWrite !== 1'b1) begin bad++; $display("FAIL wb_regwrite got=%0b want=1", bus.RegWrite); end
        total++; if (bus.WriteRegister !== 5'd5) begin bad++; $display("FAIL wb_wreg got=%0d want=5", bus.WriteRegister); end
        total++; if (bus.WriteData !== 64'hAA) begin bad++; $display("FAIL wb_wdata got=%0h want=aa", bus.WriteData); end
        step();
        total++; if (bus.RegWrite !== 1'b0) begin bad++; $display("FAIL wb_idle_regwrite got=%0b want=0", bus.RegWrite); end
        total++; if (bus.WriteData !== 64'hAA) begin bad++; $display("FAIL wb_hold_wdata got=%0h want=aa", bus.WriteData); end
    endtask

    task automatic test_fifo_drain();
        logic [4:0] regs [4];
        regs[0] = 5'd3; regs[1] = 5'd4; regs[2] = 5'd7; regs[3] = 5'd9;
        // Keep WB busy on the zero register so nothing drains while filling.
        for (int i = 0; i < 4; i++) begin
            bus.wb_valid = 1'b1; bus.wb_reg = 5'd31;
            bus.mu_valid = 1'b1; bus.mu_reg = regs[i]; bus.mu_data = 64'h100 + 64'(i);
            step();
        end
        idle_inputs();
        #1;
        total++; if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", bus.fifo_count); end
        total++; if (bus.mu_ready !== 1'b0) begin bad++; $display("FAIL full_mu_ready got=%0b want=0", bus.mu_ready); end
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== regs[k] || bus.WriteData !== 64'h100 + 64'(k)) begin
                bad++; $display("FAIL drain_%0d got=%0b/%0d/%0h want=1/%0d/%0h", k, bus.RegWrite,
                                bus.WriteRegister, bus.WriteData, regs[k], 64'h100 + 64'(k));
            end
        end
        step();
        total++; if (bus.RegWrite !== 1'b0 || bus.fifo_count !== 3'd0) begin
            bad++; $display("FAIL drain_done got=%0b/%0d want=0/0", bus.RegWrite, bus.fifo_count);
        end
    endtask

    task automatic test_starvation();
        idle_inputs();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd10; bus.wb_data = 64'd100;
        bus.mu_valid = 1'b1; bus.mu_reg = 5'd20; bus.mu_data = 64'd200;
        step();
        bus.mu_valid = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            #1;
            total++; if (bus.stall_wb !== (k == 8)) begin bad++; $display("FAIL stall_k%0d got=%0b want=%0b", k, bus.stall_wb, (k == 8)); end
            step();
            if (k < 8) begin
                total++; if (bus.WriteRegister !== 5'd10 || bus.RegWrite !== 1'b1) begin bad++; $display("FAIL starve_wb_k%0d got=%0d want=10", k, bus.WriteRegister); end
            end else begin
                total++; if (bus.WriteRegister !== 5'd20 || bus.WriteData !== 64'd200) begin bad++; $display("FAIL starve_pop got=%0d/%0h want=20/c8", bus.WriteRegister, bus.WriteData); end
            end
        end
        #1;
        total++; if (bus.stall_wb !== 1'b0 || bus.fifo_count !== 3'd0) begin bad++; $display("FAIL stall_once got=%0b/%0d want=0/0", bus.stall_wb, bus.fifo_count); end
        step();
        total++; if (bus.WriteRegister !== 5'd10 || bus.RegWrite !== 1'b1) begin bad++; $display("FAIL wb_resume got=%0d want=10", bus.WriteRegister); end
        total++; if (bus.stall_cycles !== (PerfEn ? 32'd1 : 32'd0)) begin bad++; $display("FAIL stall_cycles got=%0d want=%0d", bus.stall_cycles, PerfEn ? 1 : 0); end
        idle_inputs();
        step();
    endtask

    task automatic test_reg31();
        bus.mu_valid = 1'b1; bus.mu_reg = 5'd31; bus.mu_data = 64'h31;
        #1;
        total++; if (bus.mu_ready !== 1'b1) begin bad++; $display("FAIL r31_mu_ready got=%0b want=1", bus.mu_ready); end
        step();
        bus.mu_valid = 1'b0;
        #1;
        total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL r31_count got=%0d want=0", bus.fifo_count); end
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd31; bus.wb_data = 64'h5;
        step();
        bus.wb_valid = 1'b0;
        #1;
        total++; if (bus.RegWrite !== 1'b0) begin bad++; $display("FAIL r31_regwrite got=%0b want=0", bus.RegWrite); end
        bus.rd_reg1 = 5'd31;
        #1;
        total++; if (bus.pend_hit1 !== 1'b0) begin bad++; $display("FAIL r31_pend got=%0b want=0", bus.pend_hit1); end
    endtask

    task automatic test_pending();
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd31;
        bus.mu_valid = 1'b1; bus.mu_reg = 5'd12; bus.mu_data = 64'h12;
        bus.rd_reg1 = 5'd12; bus.rd_reg2 = 5'd13;
        #1;
        total++; if (bus.pend_hit1 !== 1'b0) begin bad++; $display("FAIL pend_before got=%0b want=0", bus.pend_hit1); end
        step();
        bus.mu_valid = 1'b0; bus.wb_valid = 1'b0;
        #1;
        total++; if (bus.pend_hit1 !== 1'b1 || bus.pend_hit2 !== 1'b0) begin bad++; $display("FAIL pend_queued got=%0b/%0b want=1/0", bus.pend_hit1, bus.pend_hit2); end
        step();
        total++; if (bus.pend_hit1 !== 1'b1 || bus.WriteRegister !== 5'd12 || bus.RegWrite !== 1'b1) begin
            bad++; $display("FAIL pend_inflight got=%0b/%0d want=1/12", bus.pend_hit1, bus.WriteRegister);
        end
        step();
        total++; if (bus.pend_hit1 !== 1'b0) begin bad++; $display("FAIL pend_after got=%0b want=0", bus.pend_hit1); end
    endtask

    task automatic test_random();
        int unsigned wb_pct;
        logic [31:0] exp_sc;
        for (int c = 0; c < 600; c++) begin
            wb_pct = (c < 300) ? 90 : 40;
            rst_n        = ($urandom_range(0, 99) != 0);
            bus.wb_valid = ($urandom_range(0, 99) < wb_pct);
            bus.wb_reg   = 5'($urandom_range(0, 31));
            bus.wb_data  = {$urandom, $urandom};
            bus.mu_valid = ($urandom_range(0, 1) == 1);
            bus.mu_reg   = 5'($urandom_range(0, 31));
            bus.mu_data  = {$urandom, $urandom};
            bus.rd_reg1  = 5'($urandom_range(0, 31));
            bus.rd_reg2  = 5'($urandom_range(0, 31));
            #1;
            exp_sc = PerfEn ? m_sc : 32'd0;
            total++;
            if (bus.mu_ready !== (rst_n && mq.size() < DEPTH) || bus.stall_wb !== m_stall_now() ||
                bus.RegWrite !== m_rw || bus.WriteRegister !== m_wr || bus.WriteData !== m_wd ||
                bus.fifo_count !== 3'(mq.size()) || bus.pend_hit1 !== m_pend(bus.rd_reg1) ||
                bus.pend_hit2 !== m_pend(bus.rd_reg2) || bus.stall_cycles !== exp_sc) begin
                bad++;
                $display("FAIL rand_c%0d got rdy=%0b st=%0b rw=%0b wr=%0d wd=%0h cnt=%0d p=%0b%0b sc=%0d want rdy=%0b st=%0b rw=%0b wr=%0d wd=%0h cnt=%0d p=%0b%0b sc=%0d",
                         c, bus.mu_ready, bus.stall_wb, bus.RegWrite, bus.WriteRegister, bus.WriteData,
                         bus.fifo_count, bus.pend_hit1, bus.pend_hit2, bus.stall_cycles,
                         (rst_n && mq.size() < DEPTH), m_stall_now(), m_rw, m_wr, m_wd, mq.size(),
                         m_pend(bus.rd_reg1), m_pend(bus.rd_reg2), exp_sc);
            end
            step();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_wb_write();
        test_fifo_drain();
        test_starvation();
        test_reg31();
        test_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
